// File: rtl/data_mem_arb_pkg.sv
// Shared types for the two-port data memory arbiter: FSM states and port index.
// Combinational definitions only; no latency or backpressure of its own.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arb_pick.sv
// Winner selection for two requesters; round-robin when DATA_MEM_ARB_RR_EN is defined, else port 0 priority.
// Purely combinational, zero latency.
// No backpressure: the caller only samples winner when it is ready to arbitrate.
module data_mem_arb_pick
    import data_mem_arb_pkg::*;
(
    input  logic      req0,
    input  logic      req1,
    input  port_idx_t last,
    output port_idx_t winner
);

`ifdef DATA_MEM_ARB_RR_EN
    always_comb begin
        winner = PORT0;
        if (req0 && req1)
            winner = (last == PORT0) ? PORT1 : PORT0;
        else if (req1)
            winner = PORT1;
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner = PORT0;
        if (!req0 && req1)
            winner = PORT1;
    end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single data memory; DATA_MEM_ARB_RR_EN selects round-robin arbitration.
// Latency: req sampled N, gnt N+1, rvalid N+2; next arbitration N+3 after a read, N+2 after a write.
// Backpressure: requesters hold req/payload until gnt; ports are only sampled in IDLE.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int MEM_WORDS   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic                   we0,
    input  logic [ADDR_LENGTH-1:0] addr0,
    input  logic [DATA_LENGTH-1:0] wdata0,
    input  logic                   req1,
    input  logic                   we1,
    input  logic [ADDR_LENGTH-1:0] addr1,
    input  logic [DATA_LENGTH-1:0] wdata1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   rvalid0,
    output logic                   rvalid1,
    output logic [DATA_LENGTH-1:0] rdata0,
    output logic [DATA_LENGTH-1:0] rdata1,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_LENGTH-1:0] mem_addr,
    output logic [DATA_LENGTH-1:0] mem_wdata,
    input  logic [DATA_LENGTH-1:0] mem_rdata
);

    arb_state_t             state_q, state_d;
    port_idx_t              win_q, last_q, winner;
    logic                   we_q;
    logic [ADDR_LENGTH-1:0] addr_q;
    logic [DATA_LENGTH-1:0] wdata_q;
    logic [DATA_LENGTH-1:0] rdata0_q, rdata1_q;
    logic                   in_range;
    logic [DATA_LENGTH-1:0] rd_val;

    data_mem_arb_pick u_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (winner)
    );

    assign in_range = (addr_q < ADDR_LENGTH'(MEM_WORDS));
    // Out-of-range reads never strobed the memory, so return zero instead of stale mem_rdata.
    assign rd_val   = in_range ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            win_q    <= PORT0;
            last_q   <= PORT0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (req0 || req1)) begin
                win_q   <= winner;
                last_q  <= winner;
                we_q    <= (winner == PORT1) ? we1    : we0;
                addr_q  <= (winner == PORT1) ? addr1  : addr0;
                wdata_q <= (winner == PORT1) ? wdata1 : wdata0;
            end
            if (state_q == RESP) begin
                if (win_q == PORT1)
                    rdata1_q <= rd_val;
                else
                    rdata0_q <= rd_val;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (req0 || req1)
                    state_d = ISSUE;
            end
            ISSUE: begin
                gnt0      = (win_q == PORT0);
                gnt1      = (win_q == PORT1);
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_read  = !we_q && in_range;
                mem_write = we_q && in_range;
                state_d   = we_q ? IDLE : RESP;
            end
            RESP: begin
                // Read data is presented in the same cycle as rvalid, then held in the port register.
                if (win_q == PORT1) begin
                    rvalid1 = 1'b1;
                    rdata1  = rd_val;
                end else begin
                    rvalid0 = 1'b1;
                    rdata0  = rd_val;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered-read memory model on the memory port.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:31];

    int total = 0;
    int bad   = 0;

    data_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write && mem_addr < 32) mem[mem_addr[4:0]] <= mem_wdata;
        if (mem_read && mem_addr < 32) mem_rdata <= mem[mem_addr[4:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 000000",
                            {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write});
        end
        total++;
        if ({rdata0, rdata1, mem_addr, mem_wdata} !== 128'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {rdata0, rdata1, mem_addr, mem_wdata});
        end
        total++;
        if (dut.state_q !== IDLE) begin
            bad++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'hA5;
        step();
        total++;
        if ({gnt0, gnt1, mem_write, mem_read} !== 4'b1010 || mem_addr !== 32'd3 || mem_wdata !== 32'hA5) begin
            bad++; $display("FAIL wr_issue: got g0g1wr=%b addr=%h wdata=%h want 1010 3 a5",
                            {gnt0, gnt1, mem_write, mem_read}, mem_addr, mem_wdata);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3; wdata0 = 32'h0;
        step();
        total++;
        if ({gnt0, mem_write, rvalid0} !== 3'b000) begin
            bad++; $display("FAIL wr_idle: got %b want 000", {gnt0, mem_write, rvalid0});
        end
        step();
        total++;
        if ({gnt0, mem_read, mem_write} !== 3'b110 || mem_addr !== 32'd3) begin
            bad++; $display("FAIL rd_issue: got %b addr=%h want 110 3", {gnt0, mem_read, mem_write}, mem_addr);
        end
        req0 = 1'b0;
        step();
        total++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 32'hA5) begin
            bad++; $display("FAIL rd_resp: got rv0=%b rv1=%b rdata0=%h want 1 0 a5", rvalid0, rvalid1, rdata0);
        end
        step();
        total++;
        if (rvalid0 !== 1'b0 || rdata0 !== 32'hA5) begin
            bad++; $display("FAIL rd_hold: got rv0=%b rdata0=%h want 0 a5", rvalid0, rdata0);
        end
    endtask

    task automatic test_simultaneous();
        int first;
        logic [31:0] exp_first, exp_second;
`ifdef DATA_MEM_ARB_RR_EN
        first = 1;
`else
        first = 0;
`endif
        exp_first  = (first == 0) ? 32'hA5 : 32'h1005;
        exp_second = (first == 0) ? 32'h1005 : 32'hA5;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd3;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd5;
        step();
        total++;
        if ({gnt1, gnt0} !== ((first == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("FAIL sim_gnt_first: got g1g0=%b want first=%0d", {gnt1, gnt0}, first);
        end
        if (first == 0) req0 = 1'b0; else req1 = 1'b0;
        step();
        total++;
        if ({rvalid1, rvalid0} !== ((first == 0) ? 2'b01 : 2'b10) ||
            ((first == 0) ? rdata0 : rdata1) !== exp_first) begin
            bad++; $display("FAIL sim_rv_first: got rv1rv0=%b rd0=%h rd1=%h want first=%0d data=%h",
                            {rvalid1, rvalid0}, rdata0, rdata1, first, exp_first);
        end
        step();
        step();
        total++;
        if ({gnt1, gnt0} !== ((first == 0) ? 2'b10 : 2'b01)) begin
            bad++; $display("FAIL sim_gnt_second: got g1g0=%b want second=%0d", {gnt1, gnt0}, 1 - first);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
        total++;
        if ({rvalid1, rvalid0} !== ((first == 0) ? 2'b10 : 2'b01) ||
            ((first == 0) ? rdata1 : rdata0) !== exp_second ||
            ((first == 0) ? rdata0 : rdata1) !== exp_first) begin
            bad++; $display("FAIL sim_rv_second: got rv1rv0=%b rd0=%h rd1=%h want second data=%h first held=%h",
                            {rvalid1, rvalid0}, rdata0, rdata1, exp_second, exp_first);
        end
        step();
    endtask

    task automatic test_out_of_range();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd32;
        step();
        total++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            bad++; $display("FAIL oob_issue: got g1=%b g0=%b rd=%b wr=%b want 1 0 0 0",
                            gnt1, gnt0, mem_read, mem_write);
        end
        req1 = 1'b0;
        step();
        total++;
        if (rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin
            bad++; $display("FAIL oob_resp: got rv1=%b rdata1=%h want 1 0", rvalid1, rdata1);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd0; wdata0 = 32'h200;
        for (int i = 0; i < 8; i++) begin
            step();
            if (gnt0 !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'(i) ||
                mem_wdata !== 32'h200 + 32'(i) || gnt1 || rvalid1) begin
                errs++; $display("FAIL b2b_issue%0d: got g0=%b wr=%b addr=%h data=%h", i, gnt0, mem_write,
                                 mem_addr, mem_wdata);
            end
            addr0 = 32'(i + 1); wdata0 = 32'h200 + 32'(i + 1);
            if (i == 7) req0 = 1'b0;
            step();
            if (gnt0 !== 1'b0 || mem_write !== 1'b0 || gnt1 || rvalid1) begin
                errs++; $display("FAIL b2b_gap%0d: got g0=%b wr=%b g1=%b rv1=%b", i, gnt0, mem_write, gnt1, rvalid1);
            end
        end
        total++;
        if (errs != 0) bad++;
        step();
        total++;
        if (mem[0] !== 32'h200 || mem[7] !== 32'h207 || mem[8] !== 32'h1008) begin
            bad++; $display("FAIL b2b_mem: got m0=%h m7=%h m8=%h want 200 207 1008", mem[0], mem[7], mem[8]);
        end
    endtask

    task automatic test_reset_abort();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        step();
        req0 = 1'b0;
        step();
        total++;
        if (rvalid0 !== 1'b1) begin
            bad++; $display("FAIL rst_resp_rv: got %b want 1", rvalid0);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write} !== 6'b0 ||
            {rdata0, rdata1, mem_addr, mem_wdata} !== 128'h0 || dut.state_q !== IDLE) begin
            bad++; $display("FAIL rst_resp_abort: got strobes=%b rd0=%h st=%0d want 0 0 IDLE",
                            {gnt0, gnt1, rvalid0, rvalid1, mem_read, mem_write}, rdata0, dut.state_q);
        end
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'h55;
        step();
        req0 = 1'b0;
        total++;
        if (gnt0 !== 1'b1) begin
            bad++; $display("FAIL rst_issue_gnt: got %b want 1", gnt0);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if ({gnt0, rvalid0, mem_write} !== 3'b000) begin
            bad++; $display("FAIL rst_issue_abort: got %b want 000", {gnt0, rvalid0, mem_write});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mem_rdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + 32'(i);
        test_reset();
        test_write_read();
        test_simultaneous();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
